prod_bcd_conv: RTL and testbench

PROD_BCD_CONV -- requirements
Module: prod_bcd_conv
Downstream of the switch multiplier: converts its 16-bit product register to 5 BCD digits for the per-digit 7-segment decoders.

---
 rtl/prod_bcd_conv.sv | 95 +++++++++
 tb/tb_prod_bcd_conv.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/prod_bcd_conv.sv
// prod_bcd_conv: 16-bit binary to 5-digit BCD by shift-and-add-3; bcd/valid 17 cycles after start, start ignored while busy.
// Optional leading-zero blanking flags when PROD_BCD_BLANK_EN is defined; otherwise blank is tied low.
module prod_bcd_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        valid,
  output logic        busy,
  output logic [4:0]  blank
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [35:0] scratch;
  logic [35:0] scratch_adj;
  logic [4:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == 5'd15) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Nibbles >= 5 would exceed 9 after the shift, so pre-correct them by 3.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 5; i++) begin
      if (scratch[16+4*i +: 4] >= 4'd5)
        scratch_adj[16+4*i +: 4] = scratch[16+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            scratch <= {20'b0, bin};
            cnt     <= '0;
          end
        end
        SHIFT: begin
          scratch <= {scratch_adj[34:0], 1'b0};
          cnt     <= cnt + 5'd1;
        end
        DONE: begin
          bcd   <= scratch[35:16];
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PROD_BCD_BLANK_EN
  logic z4, z3, z2, z1;

  assign z4 = (scratch[35:32] == 4'd0);
  assign z3 = (scratch[31:28] == 4'd0);
  assign z2 = (scratch[27:24] == 4'd0);
  assign z1 = (scratch[23:20] == 4'd0);

  // The ones digit is always shown, so a zero result still displays "0".
  always_ff @(posedge clk) begin
    if (rst)
      blank <= '0;
    else if (state == DONE)
      blank <= {z4, z4 & z3, z4 & z3 & z2, z4 & z3 & z2 & z1, 1'b0};
  end
`else
  assign blank = 5'b00000;
`endif

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Directed bench for prod_bcd_conv: table of conversions plus hand sequences for restart, reset abort and back-to-back starts.
module tb_prod_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic        valid;
  logic        busy;
  logic [4:0]  blank;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prod_bcd_conv dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .valid (valid),
    .busy  (busy),
    .blank (blank)
  );

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [4:0]  blank_m;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_blank(input logic [4:0] m);
`ifdef PROD_BCD_BLANK_EN
    return m;
`else
    return 5'b00000;
`endif
  endfunction

  // Called right after the accepting edge; returns edges until valid (-1 on timeout).
  task automatic wait_valid(output int edges, output int busy_cyc);
    edges    = -1;
    busy_cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cyc++;
      tick();
      if (valid) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic run_conv(input string name, input logic [15:0] b,
                          input logic [19:0] e_bcd, input logic [4:0] e_blank_m);
    int e, bc;
    start = 1'b1;
    bin   = b;
    tick();
    start = 1'b0;
    bin   = 16'($urandom);
    wait_valid(e, bc);
    chk({name, " latency"}, e, 17);
    chk({name, " busy_cycles"}, bc, 17);
    chk({name, " bcd"}, {12'b0, bcd}, {12'b0, e_bcd});
    chk({name, " blank"}, {27'b0, blank}, {27'b0, exp_blank(e_blank_m)});
    chk({name, " busy_at_valid"}, {31'b0, busy}, 0);
    tick();
    chk({name, " valid_drop"}, {31'b0, valid}, 0);
    chk({name, " bcd_hold"}, {12'b0, bcd}, {12'b0, e_bcd});
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (valid) n++;
    end
  endtask

  initial begin
    int e, bc, n;

    vecs[0]  = '{16'd0,     20'h00000, 5'b11110};
    vecs[1]  = '{16'd225,   20'h00225, 5'b11000};
    vecs[2]  = '{16'd65535, 20'h65535, 5'b00000};
    vecs[3]  = '{16'd9999,  20'h09999, 5'b10000};
    vecs[4]  = '{16'd1,     20'h00001, 5'b11110};
    vecs[5]  = '{16'd10,    20'h00010, 5'b11100};
    vecs[6]  = '{16'd12345, 20'h12345, 5'b00000};
    vecs[7]  = '{16'd100,   20'h00100, 5'b11000};
    vecs[8]  = '{16'd1000,  20'h01000, 5'b10000};
    vecs[9]  = '{16'd10000, 20'h10000, 5'b00000};
    vecs[10] = '{16'd42,    20'h00042, 5'b11100};
    vecs[11] = '{16'd59999, 20'h59999, 5'b00000};

    // Reset with start held high: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    bin   = 16'h1234;
    tick();
    tick();
    chk("reset busy",  {31'b0, busy},  0);
    chk("reset valid", {31'b0, valid}, 0);
    chk("reset bcd",   {12'b0, bcd},   0);
    chk("reset blank", {27'b0, blank}, 0);

    // First conversion starts in the first cycle after reset release.
    rst = 1'b0;
    for (int i = 0; i < 12; i++)
      run_conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].blank_m);

    // Second start and input change mid-conversion are ignored.
    start = 1'b1;
    bin   = 16'd100;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    bin   = 16'd7;
    tick();
    start = 1'b0;
    bin   = 16'd555;
    wait_valid(e, bc);
    chk("restart latency", e, 12);
    chk("restart bcd", {12'b0, bcd}, 32'h00100);
    count_valid(25, n);
    chk("restart extra_valid", n, 0);
    chk("restart idle", {31'b0, busy}, 0);

    // Reset mid-conversion aborts with no valid and clears bcd.
    start = 1'b1;
    bin   = 16'd42;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy",  {31'b0, busy},  0);
    chk("abort valid", {31'b0, valid}, 0);
    chk("abort bcd",   {12'b0, bcd},   0);
    chk("abort blank", {27'b0, blank}, 0);
    count_valid(25, n);
    chk("abort no_valid", n, 0);
    run_conv("after_abort", 16'd42, 20'h00042, 5'b11100);

    // Start re-asserted in the valid cycle: next valid exactly 18 cycles later.
    start = 1'b1;
    bin   = 16'd225;
    tick();
    start = 1'b0;
    wait_valid(e, bc);
    chk("b2b first latency", e, 17);
    chk("b2b first bcd", {12'b0, bcd}, 32'h00225);
    start = 1'b1;
    bin   = 16'd12;
    tick();
    start = 1'b0;
    wait_valid(e, bc);
    chk("b2b period", e + 1, 18);
    chk("b2b second bcd", {12'b0, bcd}, 32'h00012);
    chk("b2b second blank", {27'b0, blank}, {27'b0, exp_blank(5'b11100)});

    // Start held high: conversions repeat, bin resampled at each acceptance.
    start = 1'b1;
    bin   = 16'd3;
    tick();
    wait_valid(e, bc);
    chk("held first latency", e, 17);
    chk("held first bcd", {12'b0, bcd}, 32'h00003);
    bin = 16'd4;
    wait_valid(e, bc);
    chk("held period", e, 18);
    chk("held second bcd", {12'b0, bcd}, 32'h00004);
    start = 1'b0;
    tick();
    chk("held valid_drop", {31'b0, valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
